pipelined_rca_param: RTL and testbench
======================================

Name: pipelined_rca_param

Overview:
- Parametrised, fully pipelined ripple-carry adder/subtractor. It is the generalised successor to the team's fixed 4-bit pipelined ripple-carry adder.
- Splits a WIDTH-bit operation into STAGES = WIDTH/CHUNK chunks. Each chunk ripples in its own register stage.
- Adds a valid flag, a pipeline enable, a subtract mode and a signed overflow flag. Sits in the datapath as a drop-in streaming arithmetic unit with throughput of one operation per enabled cycle.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of CHUNK; otherwise elaboration fails.
- CHUNK, 4, bits added per pipeline stage. STAGES = WIDTH/CHUNK, derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  pipeline enable. 0 freezes every register.
- in_valid  input  1  the A/B/carry_in/sub vector is a real operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0. Ignored when sub=1.
- sub  input  1  0: A+B+carry_in. 1: A-B, computed as A+~B+1.
- Sum  output  WIDTH  result.
- carry_out  output  1  carry out of the MSB. In subtract mode: 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  Sum/carry_out/overflow belong to a valid operation.

Behaviour:
- Reset: rst_n low clears all pipeline registers immediately, without waiting for a clock edge. Sum=0, carry_out=0, overflow=0, out_valid=0. This applies mid-operation too: every in-flight result is discarded. The first edge after rst_n rises may sample a new vector.
- Sampling: on a rising edge with en=1, the pipeline samples A, B, carry_in, sub and in_valid. In the same edge, stage 0 adds chunk 0 (bits CHUNK-1:0).
- Stage k (1..STAGES-1): on the next en=1 edge it adds chunk k of the skewed operands, using the registered carry from stage k-1.
- Skew registers: upper operand chunks are delayed so each chunk reaches its adder in the cycle its carry arrives. Lower result chunks are delayed so all chunks of Sum leave together.
- Subtract: inversion of B and forcing carry 1 happen before stage 0 registration. sub travels with its operands; mixing add and sub on consecutive cycles is legal.
- Latency: a vector sampled at en-qualified edge t is on the outputs after en-qualified edge t+STAGES-1. STAGES en=1 edges in total, counting the sampling edge.
  - WIDTH=16, CHUNK=4: result after the 4th edge.
  - STAGES=1 degenerates to a single registered adder with latency 1.
- Throughput: one vector per en=1 cycle, no bubbles required between vectors.
- in_valid=0 vectors still propagate; they emerge with out_valid=0. Sum contents are then don't-care but deterministic.
- en=0 stalls: all registers, including outputs and out_valid, hold. No vector is lost or duplicated, and latency in en=1 edges is unchanged.
- Arithmetic: all chunks are WIDTH-exact and Sum wraps modulo 2^WIDTH.
  - carry_out is the carry out of bit WIDTH-1.
  - overflow is computed from the carry into bit WIDTH-1 versus carry_out, in both modes.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan (WIDTH=16, CHUNK=4):
- Reset: hold rst_n=0 for 3 cycles with random inputs and en=1 -> Sum=0x0000, carry_out=0, overflow=0, out_valid=0. Assert rst_n low asynchronously mid-cycle while 3 vectors are in flight -> out_valid drops before the next edge, and no stale result appears after release.
- Chunk-boundary carry: A=0x00FF, B=0x0001, carry_in=0, sub=0, in_valid=1 for one cycle -> after the 4th edge Sum=0x0100, carry_out=0, overflow=0, out_valid=1 for exactly one cycle.
- Full ripple: A=0xFFFF, B=0x0001, carry_in=1 -> Sum=0x0001, carry_out=1, overflow=0. A=0x7FFF, B=0x0001, carry_in=0 -> Sum=0x8000, overflow=1.
- Subtract: A=0x0005, B=0x0007, sub=1 -> Sum=0xFFFE, carry_out=0, overflow=0. A=0x8000, B=0x0001, sub=1 -> Sum=0x7FFF, carry_out=1, overflow=1.
- Streaming: 4 back-to-back vectors (0x0001+0x0001, 0x1234+0x1111, 0xFFFF+0x0000 with carry_in=1, 0x00F0-0x000F) -> out_valid high for 4 consecutive cycles with Sum = 0x0002, 0x2345, 0x0000 (carry_out=1), 0x00E1, in order.
- Stall: issue 0x0F0F+0x0101, then deassert en for 2 cycles after the second edge -> outputs hold. Sum=0x1010 with out_valid=1 appears 2 cycles later than unstalled, exactly once.

Source files
------------

// File: rtl/pipelined_rca_param.sv
// pipelined_rca_param: WIDTH-bit pipelined ripple-carry adder/subtractor, CHUNK bits per stage.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset, clears every pipeline register
//   en        pipeline enable; 0 holds every register
//   in_valid  qualifies the A/B/carry_in/sub vector
//   A, B      operands
//   carry_in  carry into bit 0; ignored when sub=1
//   sub       0: A+B+carry_in, 1: A-B (A+~B+1)
//   Sum       result, modulo 2^WIDTH
//   carry_out carry out of the MSB (in subtract mode 1 = no borrow)
//   overflow  signed overflow: carry into MSB xor carry out of MSB
//   out_valid Sum/carry_out/overflow belong to a valid operation
module pipelined_rca_param #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    input  logic             sub,
    output logic [WIDTH-1:0] Sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             out_valid
);
    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad
        $error("pipelined_rca_param: WIDTH must be a positive multiple of CHUNK");
    end

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_st
        // Stage k sees only the operand bits not yet consumed, so the skew
        // registers shrink by CHUNK per stage while the sum register grows.
        localparam int W = WIDTH - k * CHUNK;
        logic [W-1:0]             a_i, b_i;
        logic                     c_i, v_i;
        logic [CHUNK:0]           r;
        logic [(k+1)*CHUNK-1:0]   s_n, s_q;
        logic                     c_q, v_q;

        if (k == 0) begin : g_in
            assign a_i = A;
            assign b_i = sub ? ~B : B;
            assign c_i = sub | carry_in;
            assign v_i = in_valid;
            assign s_n = r[CHUNK-1:0];
        end else begin : g_in
            assign a_i = g_st[k-1].g_fwd.a_q;
            assign b_i = g_st[k-1].g_fwd.b_q;
            assign c_i = g_st[k-1].c_q;
            assign v_i = g_st[k-1].v_q;
            assign s_n = {r[CHUNK-1:0], g_st[k-1].s_q};
        end

        assign r = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                s_q <= s_n;
                c_q <= r[CHUNK];
                v_q <= v_i;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [W-CHUNK-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_i[W-1:CHUNK];
                    b_q <= b_i[W-1:CHUNK];
                end
            end
        end else begin : g_out
            // a^b^sum at the MSB recovers the carry into the MSB.
            logic o_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    o_q <= 1'b0;
                else if (en)
                    o_q <= a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ r[CHUNK-1] ^ r[CHUNK];
            end
        end
    end

    assign Sum       = g_st[STAGES-1].s_q;
    assign carry_out = g_st[STAGES-1].c_q;
    assign overflow  = g_st[STAGES-1].g_out.o_q;
    assign out_valid = g_st[STAGES-1].v_q;
endmodule

// File: tb/tb_pipelined_rca_param.sv
// tb_pipelined_rca_param: scoreboard bench for pipelined_rca_param (WIDTH=16, CHUNK=4).
module tb_pipelined_rca_param;
    logic        clk = 0, rst_n = 0, en = 1, in_valid = 0, carry_in = 0, sub = 0;
    logic [15:0] A = 0, B = 0, Sum;
    logic        carry_out, overflow, out_valid;
    int          cyc = 0, tests = 0, fails = 0;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          cy;
    } exp_t;
    exp_t q[$];

    pipelined_rca_param #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .A(A), .B(B), .carry_in(carry_in), .sub(sub),
        .Sum(Sum), .carry_out(carry_out), .overflow(overflow), .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", n, got, want);
        end
    endtask

    // Called at a negedge; result expected after the 4th enabled edge (+stall cycles).
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                         input logic vld, input logic [15:0] s, input logic co, input logic ov,
                         input int stall);
        A = a; B = b; carry_in = ci; sub = sb; in_valid = vld;
        if (vld) q.push_back(exp_t'{s: s, co: co, ov: ov, cy: cyc + 4 + stall});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            A = 16'($urandom); B = 16'($urandom); carry_in = 1'($urandom); sub = 1'($urandom);
            in_valid = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        logic e;
        exp_t x;
        forever begin
            @(posedge clk);
            e = en;
            #1;
            if (e && rst_n && out_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: Sum=%h out_valid=1 at cycle %0d with nothing pending", Sum, cyc);
                end else begin
                    x = q.pop_front();
                    if ({Sum, carry_out, overflow} !== {x.s, x.co, x.ov} || cyc != x.cy) begin
                        fails++;
                        $display("FAIL result: got Sum=%h co=%b ov=%b cycle=%0d, want Sum=%h co=%b ov=%b cycle=%0d",
                                 Sum, carry_out, overflow, cyc, x.s, x.co, x.ov, x.cy);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 0; en = 1;
        repeat (3) begin
            A = 16'($urandom); B = 16'($urandom); carry_in = 1'($urandom); sub = 1'($urandom);
            in_valid = 1;
            @(negedge clk);
            chk("reset_state", {13'b0, Sum, carry_out, overflow, out_valid}, 32'h0);
        end
        rst_n = 1; in_valid = 0;
        // chunk-boundary carry, followed by an invalid vector that must not emerge as valid
        issue(16'h00FF, 16'h0001, 0, 0, 1, 16'h0100, 0, 0, 0);
        issue(16'hFFFF, 16'hFFFF, 1, 0, 0, 16'h0000, 0, 0, 0);
        idle(4);
        // full ripple and signed overflow
        issue(16'hFFFF, 16'h0001, 1, 0, 1, 16'h0001, 1, 0, 0);
        issue(16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1, 0);
        // subtract, carry_in must be ignored
        issue(16'h0005, 16'h0007, 0, 1, 1, 16'hFFFE, 0, 0, 0);
        issue(16'h8000, 16'h0001, 1, 1, 1, 16'h7FFF, 1, 1, 0);
        idle(4);
        // streaming, mixed add/sub back to back
        issue(16'h0001, 16'h0001, 0, 0, 1, 16'h0002, 0, 0, 0);
        issue(16'h1234, 16'h1111, 0, 0, 1, 16'h2345, 0, 0, 0);
        issue(16'hFFFF, 16'h0000, 1, 0, 1, 16'h0000, 1, 0, 0);
        issue(16'h00F0, 16'h000F, 0, 1, 1, 16'h00E1, 1, 0, 0);
        idle(6);
        // stall: en low for two edges after the second enabled edge
        issue(16'h0F0F, 16'h0101, 0, 0, 1, 16'h1010, 0, 0, 2);
        idle(1);
        en = 0;
        repeat (2) @(negedge clk);
        chk("stall_hold_valid", {31'b0, out_valid}, 32'h0);
        en = 1;
        idle(6);
        // asynchronous reset with three vectors in flight
        issue(16'h0011, 16'h0022, 0, 0, 1, 16'h0033, 0, 0, 0);
        issue(16'h1111, 16'h0001, 0, 0, 1, 16'h1112, 0, 0, 0);
        issue(16'h2222, 16'h0002, 0, 0, 1, 16'h2224, 0, 0, 0);
        issue(16'h3333, 16'h0003, 0, 0, 1, 16'h3336, 0, 0, 0);
        in_valid = 0;
        chk("pre_reset_valid", {31'b0, out_valid}, 32'h1);
        #2 rst_n = 0;
        #1 chk("async_reset_clear", {13'b0, Sum, carry_out, overflow, out_valid}, 32'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1;
        idle(8);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
